wb_pic186: RTL and testbench

- 80186-style programmable interrupt controller on Wishbone slave 2 (I/O 0xFF20-0xFF3E).
- Replaces the ad-hoc tube IRQ/NMI edge latches in the co-processor top level.
- Synchronises and edge- or level-detects up to four maskable sources plus NMI, and resolves priority against in-service state.
- Drives the CPU interrupt handshake (intr/inta, nmi/nmia) and the vector word fed onto the CPU data bus during acknowledge.

---
 rtl/wb_pic186_pkg.sv | 38 +++
 rtl/wb_pic186_prio.sv | 50 +++++
 rtl/wb_pic186.sv | 198 +++++++++++++++++++
 tb/tb_wb_pic186.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pic186_pkg.sv
// Shared constants for the 80186-style interrupt controller: register word
// indices, control-field layout and a priority-pick helper.
package wb_pic186_pkg;

  localparam logic [3:0] IDX_EOI  = 4'd1;
  localparam logic [3:0] IDX_MASK = 4'd4;
  localparam logic [3:0] IDX_PRM  = 4'd5;
  localparam logic [3:0] IDX_IRR  = 4'd6;
  localparam logic [3:0] IDX_ISR  = 4'd7;
  localparam logic [3:0] IDX_POLL = 4'd8;
  localparam logic [3:0] IDX_CTL0 = 4'd12;

  localparam int CTL_LTM = 4;
  localparam int CTL_MSK = 3;

  localparam logic [4:0] CTL_RESET = 5'b01_111;
  localparam logic [2:0] PRM_RESET = 3'd7;

  // Returns {found, index} of the set bit with the lowest 3-bit priority;
  // ties resolve to the lowest index because only a strictly better PR replaces.
  function automatic logic [2:0] pick_best(input logic [3:0] bits, input logic [11:0] prs);
    logic       found;
    logic [1:0] idx;
    logic [2:0] best;
    found = 1'b0;
    idx   = 2'd0;
    best  = 3'd7;
    for (int i = 0; i < 4; i++) begin
      if (bits[i] && (!found || prs[3*i +: 3] < best)) begin
        found = 1'b1;
        idx   = 2'(i);
        best  = prs[3*i +: 3];
      end
    end
    return {found, idx};
  endfunction

endpackage

// File: rtl/wb_pic186_prio.sv
// Combinational priority encoder: picks the best pending candidate and
// decides whether it may pre-empt what is currently in service.
module pic_prio_resolve
  import wb_pic186_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0]   cand_i,
  input  logic [3*NUM_IRQ-1:0] pr_i,
  input  logic [NUM_IRQ-1:0]   isr_i,
  output logic [1:0]           win_idx_o,
  output logic                 win_valid_o,
  output logic                 irq_ok_o,
  output logic [1:0]           isr_idx_o,
  output logic                 isr_valid_o
);

  logic [3:0]  cand4;
  logic [3:0]  isr4;
  logic [11:0] pr12;
  logic [2:0]  win_sel;
  logic [2:0]  isr_sel;
  logic [3:0]  win_pr;
  logic [3:0]  isr_min;
  int          wi;
  int          si;

  always_comb begin
    cand4 = '0;
    isr4  = '0;
    pr12  = '0;
    cand4[NUM_IRQ-1:0]   = cand_i;
    isr4[NUM_IRQ-1:0]    = isr_i;
    pr12[3*NUM_IRQ-1:0]  = pr_i;
    win_sel = pick_best(cand4, pr12);
    isr_sel = pick_best(isr4, pr12);
    wi      = int'(win_sel[1:0]);
    si      = int'(isr_sel[1:0]);
    win_pr  = {1'b0, pr12[3*wi +: 3]};
    // An empty in-service set behaves as priority level 8, below everything.
    isr_min = isr_sel[2] ? {1'b0, pr12[3*si +: 3]} : 4'd8;

    win_idx_o   = win_sel[1:0];
    win_valid_o = win_sel[2];
    irq_ok_o    = win_sel[2] && (win_pr < isr_min);
    isr_idx_o   = isr_sel[1:0];
    isr_valid_o = isr_sel[2];
  end

endmodule

// File: rtl/wb_pic186.sv
// 80186-style programmable interrupt controller on a Wishbone slave port;
// synchronises IRQ/NMI, tracks IRR/ISR and drives the CPU acknowledge vector.
module wb_pic186
  import wb_pic186_pkg::*;
#(
  parameter int          NUM_IRQ      = 4,
  parameter logic [7:0]  VEC_BASE     = 8'h0C,
  parameter logic [15:0] NMI_VEC      = 16'h0002,
  parameter logic [7:0]  SPURIOUS_VEC = 8'h07
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         wb_adr_i,
  input  logic [15:0]        wb_dat_i,
  output logic [15:0]        wb_dat_o,
  input  logic [1:0]         wb_sel_i,
  input  logic               wb_we_i,
  input  logic               wb_stb_i,
  input  logic               wb_cyc_i,
  output logic               wb_ack_o,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               nmi_i,
  output logic               intr_o,
  input  logic               inta_i,
  output logic               nmi_o,
  input  logic               nmia_i,
  output logic [15:0]        vec_o
);

  logic [NUM_IRQ-1:0] irq_s1_q, irq_s1_d, irq_s2_q, irq_s2_d, irq_h_q, irq_h_d;
  logic               nmi_s1_q, nmi_s1_d, nmi_s2_q, nmi_s2_d, nmi_h_q, nmi_h_d;
  logic               inta_h_q, inta_h_d;
  logic [NUM_IRQ-1:0] irr_q, irr_d, isr_q, isr_d;
  logic [NUM_IRQ-1:0][4:0] ctl_q, ctl_d;
  logic [2:0]         prm_q, prm_d;
  logic               intr_q, intr_d;
  logic               nmi_q, nmi_d;
  logic [7:0]         vec_type_q, vec_type_d;
  logic               ack_q, ack_d;

  logic [NUM_IRQ-1:0]   irq_edge, ltm, msk, cand;
  logic [NUM_IRQ-1:0]   eoi_clr, ack_set, ack_clr;
  logic [3*NUM_IRQ-1:0] pr_vec;
  logic                 nmi_edge, inta_rise, wr_en;
  logic [1:0]           win_idx, isr_idx;
  logic                 win_valid, irq_ok, isr_valid;
  logic [15:0]          rdata;
  logic                 unused_dat;

  assign unused_dat = ^wb_dat_i[14:5];

  always_comb begin
    irq_edge  = irq_s2_q & ~irq_h_q;
    nmi_edge  = nmi_s2_q & ~nmi_h_q;
    inta_rise = inta_i & ~inta_h_q;
    for (int i = 0; i < NUM_IRQ; i++) begin
      ltm[i]          = ctl_q[i][CTL_LTM];
      msk[i]          = ctl_q[i][CTL_MSK];
      pr_vec[3*i +: 3] = ctl_q[i][2:0];
      cand[i]         = irr_q[i] & ~msk[i] & (ctl_q[i][2:0] <= prm_q);
    end
  end

  pic_prio_resolve #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .cand_i      (cand),
    .pr_i        (pr_vec),
    .isr_i       (isr_q),
    .win_idx_o   (win_idx),
    .win_valid_o (win_valid),
    .irq_ok_o    (irq_ok),
    .isr_idx_o   (isr_idx),
    .isr_valid_o (isr_valid)
  );

  // Wishbone handshake: a request is cyc&stb while ack is low; ack rises for
  // exactly one cycle, writes commit on that ack cycle and read data is valid with it.
  always_comb begin
    ack_d = wb_cyc_i & wb_stb_i & ~ack_q;
    wr_en = ack_q & wb_cyc_i & wb_stb_i & wb_we_i;

    irq_s1_d = irq_i;
    irq_s2_d = irq_s1_q;
    irq_h_d  = irq_s2_q;
    nmi_s1_d = nmi_i;
    nmi_s2_d = nmi_s1_q;
    nmi_h_d  = nmi_s2_q;
    inta_h_d = inta_i;

    ctl_d = ctl_q;
    prm_d = prm_q;
    if (wr_en && wb_sel_i[0]) begin
      if (wb_adr_i == IDX_MASK) begin
        for (int i = 0; i < NUM_IRQ; i++) ctl_d[i][CTL_MSK] = wb_dat_i[i];
      end
      if (wb_adr_i == IDX_PRM) prm_d = wb_dat_i[2:0];
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (wb_adr_i == 4'(IDX_CTL0 + 4'(i))) ctl_d[i] = wb_dat_i[4:0];
      end
    end

    eoi_clr = '0;
    if (wr_en && wb_sel_i[1] && wb_adr_i == IDX_EOI) begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        if (wb_dat_i[15]) begin
          if (isr_valid && isr_idx == 2'(i)) eoi_clr[i] = 1'b1;
        end else if (wb_dat_i[1:0] == 2'(i)) begin
          eoi_clr[i] = 1'b1;
        end
      end
    end

    ack_set    = '0;
    ack_clr    = '0;
    vec_type_d = vec_type_q;
    intr_d     = irq_ok;
    if (inta_rise) begin
      intr_d = 1'b0;
      if (win_valid) begin
        vec_type_d = VEC_BASE + {6'b0, win_idx};
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (win_idx == 2'(i)) begin
            ack_set[i] = 1'b1;
            ack_clr[i] = ~ltm[i];
          end
        end
      end else begin
        vec_type_d = SPURIOUS_VEC;
      end
    end

    isr_d = (isr_q & ~eoi_clr) | ack_set;
    // Edge set is applied after the acknowledge clear so a coincident edge survives.
    for (int i = 0; i < NUM_IRQ; i++) begin
      irr_d[i] = ltm[i] ? irq_s2_q[i] : ((irr_q[i] & ~ack_clr[i]) | irq_edge[i]);
    end

    nmi_d = nmi_edge | (nmi_q & ~nmia_i);
  end

  always_comb begin
    rdata = '0;
    case (wb_adr_i)
      IDX_MASK: rdata[NUM_IRQ-1:0] = msk;
      IDX_PRM:  rdata[2:0]         = prm_q;
      IDX_IRR:  rdata[NUM_IRQ-1:0] = irr_q;
      IDX_ISR:  rdata[NUM_IRQ-1:0] = isr_q;
      IDX_POLL: rdata              = {intr_q, 12'b0, 1'b0, win_idx};
      default: begin
        for (int i = 0; i < NUM_IRQ; i++) begin
          if (wb_adr_i == 4'(IDX_CTL0 + 4'(i))) rdata[4:0] = ctl_q[i];
        end
      end
    endcase
    wb_dat_o = (ack_q && !wb_we_i) ? rdata : 16'h0000;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_s1_q   <= '0;
      irq_s2_q   <= '0;
      irq_h_q    <= '0;
      nmi_s1_q   <= 1'b0;
      nmi_s2_q   <= 1'b0;
      nmi_h_q    <= 1'b0;
      inta_h_q   <= 1'b0;
      irr_q      <= '0;
      isr_q      <= '0;
      ctl_q      <= {NUM_IRQ{CTL_RESET}};
      prm_q      <= PRM_RESET;
      intr_q     <= 1'b0;
      nmi_q      <= 1'b0;
      vec_type_q <= SPURIOUS_VEC;
      ack_q      <= 1'b0;
    end else begin
      irq_s1_q   <= irq_s1_d;
      irq_s2_q   <= irq_s2_d;
      irq_h_q    <= irq_h_d;
      nmi_s1_q   <= nmi_s1_d;
      nmi_s2_q   <= nmi_s2_d;
      nmi_h_q    <= nmi_h_d;
      inta_h_q   <= inta_h_d;
      irr_q      <= irr_d;
      isr_q      <= isr_d;
      ctl_q      <= ctl_d;
      prm_q      <= prm_d;
      intr_q     <= intr_d;
      nmi_q      <= nmi_d;
      vec_type_q <= vec_type_d;
      ack_q      <= ack_d;
    end
  end

  assign wb_ack_o = ack_q;
  assign intr_o   = intr_q;
  assign nmi_o    = nmi_q;
  assign vec_o    = nmia_i ? NMI_VEC : {8'h00, vec_type_q};

endmodule

// File: tb/tb_wb_pic186.sv
// Directed plus randomized bench for wb_pic186 with a priority reference model.
module tb_wb_pic186;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  wb_adr_i;
  logic [15:0] wb_dat_i;
  logic [15:0] wb_dat_o;
  logic [1:0]  wb_sel_i;
  logic        wb_we_i, wb_stb_i, wb_cyc_i, wb_ack_o;
  logic [3:0]  irq_i;
  logic        nmi_i, intr_o, inta_i, nmi_o, nmia_i;
  logic [15:0] vec_o;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic        ack_after;
  logic [15:0] rd;

  logic [2:0]  pr_m[4];
  logic        msk_m[4];
  logic [2:0]  prm_m;
  logic [3:0]  irr_m, subset;
  logic        found;
  logic [1:0]  w;

  wb_pic186 dut (
    .clk(clk), .rst(rst),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i),
    .wb_cyc_i(wb_cyc_i), .wb_ack_o(wb_ack_o),
    .irq_i(irq_i), .nmi_i(nmi_i), .intr_o(intr_o), .inta_i(inta_i),
    .nmi_o(nmi_o), .nmia_i(nmia_i), .vec_o(vec_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic wb_cycle(input logic [3:0] idx, input logic we, input logic [15:0] wdat,
                          input logic [1:0] sel, output logic [15:0] rdat);
    int waited = 0;
    wb_adr_i = idx; wb_we_i = we; wb_dat_i = wdat; wb_sel_i = sel;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    tick(1);
    while (!wb_ack_o && waited < 8) begin
      tick(1);
      waited++;
    end
    if (!wb_ack_o) check("wb_ack_timeout", 16'h0000, 16'h0001);
    rdat = wb_dat_o;
    tick(1);
    ack_after = wb_ack_o;
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
  endtask

  task automatic wb_write(input logic [3:0] idx, input logic [15:0] d, input logic [1:0] sel);
    logic [15:0] dummy;
    wb_cycle(idx, 1'b1, d, sel, dummy);
  endtask

  task automatic wb_read(input logic [3:0] idx, output logic [15:0] d);
    wb_cycle(idx, 1'b0, 16'h0000, 2'b11, d);
  endtask

  task automatic wait_intr(input string tag, input logic exp, input int budget);
    int n = 0;
    while (intr_o !== exp && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, {15'b0, intr_o}, {15'b0, exp});
  endtask

  // Raise inta for one edge, check the latched vector and the forced-low intr.
  task automatic do_inta(input string tag, input logic [15:0] exp_vec);
    inta_i = 1'b1;
    tick(1);
    check(tag, vec_o, exp_vec);
    check({tag, "_intr_low"}, {15'b0, intr_o}, 16'h0000);
    inta_i = 1'b0;
    tick(1);
  endtask

  initial begin
    rst = 1'b1;
    wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0;
    wb_we_i = 1'b0; wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    irq_i = '0; nmi_i = 1'b0; inta_i = 1'b0; nmia_i = 1'b0;
    tick(3);
    rst = 1'b0;
    tick(1);

    // Reset state
    check("rst_intr", {15'b0, intr_o}, 16'h0000);
    check("rst_nmi", {15'b0, nmi_o}, 16'h0000);
    check("rst_vec", vec_o, 16'h0007);
    check("rst_ack", {15'b0, wb_ack_o}, 16'h0000);
    check("rst_dat", wb_dat_o, 16'h0000);
    wb_read(4'd12, rd); check("rst_ctl0", rd, 16'h000F);
    wb_read(4'd5, rd);  check("rst_prm", rd, 16'h0007);
    wb_read(4'd4, rd);  check("rst_mask", rd, 16'h000F);
    wb_read(4'd7, rd);  check("rst_isr", rd, 16'h0000);

    // Masked source captured but not requested; unmask then acknowledge
    irq_i[0] = 1'b1;
    tick(5);
    wb_read(4'd6, rd); check("masked_irr", rd, 16'h0001);
    check("masked_no_intr", {15'b0, intr_o}, 16'h0000);
    wb_write(4'd12, 16'h001F, 2'b10);
    wb_read(4'd12, rd); check("ctl_hi_byte_ignored", rd, 16'h000F);
    wb_write(4'd12, 16'h0000, 2'b01);
    wait_intr("unmask_intr", 1'b1, 2);
    do_inta("ack_int0", 16'h000C);
    wb_read(4'd7, rd); check("ack_isr", rd, 16'h0001);
    wb_read(4'd6, rd); check("ack_irr", rd, 16'h0000);
    wb_write(4'd1, 16'h8000, 2'b01);
    wb_read(4'd7, rd); check("eoi_lo_sel_ignored", rd, 16'h0001);
    wb_write(4'd1, 16'h8000, 2'b11);
    wb_read(4'd7, rd); check("eoi_clear", rd, 16'h0000);
    irq_i[0] = 1'b0;

    // Nesting: INT0 PR3 in service, INT1 PR1 pre-empts, INT0 blocked until EOI
    wb_write(4'd12, 16'h0003, 2'b01);
    wb_write(4'd13, 16'h0001, 2'b01);
    tick(3);
    irq_i[0] = 1'b1;
    wait_intr("nest_int0_req", 1'b1, 8);
    do_inta("nest_ack_int0", 16'h000C);
    irq_i[0] = 1'b0;
    irq_i[1] = 1'b1;
    wait_intr("nest_int1_req", 1'b1, 8);
    do_inta("nest_ack_int1", 16'h000D);
    wb_read(4'd7, rd); check("nest_isr", rd, 16'h0003);
    irq_i[1] = 1'b0;
    irq_i[0] = 1'b1;
    tick(6);
    check("nest_blocked", {15'b0, intr_o}, 16'h0000);
    wb_read(4'd6, rd); check("nest_irr_pending", rd, 16'h0001);
    wb_write(4'd1, 16'h8000, 2'b11);
    wb_read(4'd7, rd); check("nonspec_eoi", rd, 16'h0001);
    check("still_blocked", {15'b0, intr_o}, 16'h0000);
    wb_write(4'd1, 16'h0000, 2'b11);
    wb_read(4'd7, rd); check("spec_eoi", rd, 16'h0000);
    wait_intr("pending_int0_req", 1'b1, 4);
    do_inta("ack_pending_int0", 16'h000C);
    wb_write(4'd1, 16'h8000, 2'b11);
    irq_i[0] = 1'b0;

    // Level mode and spurious acknowledge
    wb_write(4'd14, 16'h0010, 2'b01);
    irq_i[2] = 1'b1;
    wait_intr("level_req", 1'b1, 8);
    irq_i[2] = 1'b0;
    wait_intr("level_drop", 1'b0, 8);
    do_inta("spurious", 16'h0007);
    wb_read(4'd7, rd); check("spurious_isr", rd, 16'h0000);

    // NMI
    nmi_i = 1'b1;
    tick(2);
    check("nmi_early", {15'b0, nmi_o}, 16'h0000);
    tick(1);
    check("nmi_set", {15'b0, nmi_o}, 16'h0001);
    nmia_i = 1'b1;
    #1;
    check("nmi_vec", vec_o, 16'h0002);
    tick(1);
    check("nmi_clear", {15'b0, nmi_o}, 16'h0000);
    nmia_i = 1'b0;
    nmi_i = 1'b0;
    #1;
    check("vec_after_nmia", vec_o, 16'h0007);

    // Wishbone read of IRR with one-cycle ack
    wb_write(4'd15, 16'h000B, 2'b01);
    irq_i[3] = 1'b1;
    tick(5);
    wb_read(4'd6, rd); check("wb_irr_read", rd, 16'h0008);
    check("wb_ack_one_cycle", {15'b0, ack_after}, 16'h0000);
    irq_i[3] = 1'b0;
    tick(3);

    // Randomized priority rounds against the reference model
    irr_m = 4'h8;
    for (int r = 0; r < 12; r++) begin
      prm_m = 3'($urandom_range(2, 7));
      for (int i = 0; i < 4; i++) begin
        pr_m[i]  = 3'($urandom_range(0, 7));
        msk_m[i] = ($urandom_range(0, 3) == 0);
        wb_write(4'(12 + i), {11'b0, 1'b0, msk_m[i], pr_m[i]}, 2'b01);
      end
      wb_write(4'd5, {13'b0, prm_m}, 2'b01);
      wb_read(4'd4, rd);
      check("rnd_mask", rd, {12'b0, msk_m[3], msk_m[2], msk_m[1], msk_m[0]});
      wb_read(4'd5, rd);
      check("rnd_prm", rd, {13'b0, prm_m});
      subset = 4'($urandom_range(1, 15));
      irq_i = subset;
      tick(5);
      irr_m = irr_m | subset;
      wb_read(4'd6, rd);
      check("rnd_irr", rd, {12'b0, irr_m});
      // Scan priority levels from best to worst, then indices low to high.
      found = 1'b0;
      w = 2'd0;
      for (int p = 0; p < 8; p++) begin
        for (int i = 0; i < 4; i++) begin
          if (!found && irr_m[i] && !msk_m[i] && pr_m[i] == 3'(p) && 3'(p) <= prm_m) begin
            found = 1'b1;
            w = 2'(i);
          end
        end
      end
      wb_read(4'd8, rd);
      if (found) check("rnd_poll", rd, {1'b1, 12'b0, 1'b0, w});
      else       check("rnd_poll_idle", rd & 16'h8000, 16'h0000);
      do_inta("rnd_vec", found ? 16'(8'h0C + {6'b0, w}) : 16'h0007);
      if (found) begin
        irr_m[w] = 1'b0;
        wb_read(4'd7, rd);
        check("rnd_isr", rd, 16'(4'b0001 << w));
        wb_write(4'd1, {14'b0, w}, 2'b11);
      end
      wb_read(4'd7, rd);
      check("rnd_isr_empty", rd, 16'h0000);
      irq_i = '0;
      tick(4);
    end

    // Asynchronous reset in the middle of activity
    wb_write(4'd12, 16'h0000, 2'b01);
    irq_i[0] = 1'b1;
    wait_intr("pre_rst_req", 1'b1, 8);
    do_inta("pre_rst_ack", 16'h000C);
    nmi_i = 1'b1;
    tick(4);
    check("pre_rst_nmi", {15'b0, nmi_o}, 16'h0001);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_intr", {15'b0, intr_o}, 16'h0000);
    check("async_rst_nmi", {15'b0, nmi_o}, 16'h0000);
    check("async_rst_vec", vec_o, 16'h0007);
    check("async_rst_ack", {15'b0, wb_ack_o}, 16'h0000);
    irq_i = '0;
    nmi_i = 1'b0;
    tick(2);
    rst = 1'b0;
    tick(2);
    wb_read(4'd7, rd);  check("post_rst_isr", rd, 16'h0000);
    wb_read(4'd6, rd);  check("post_rst_irr", rd, 16'h0000);
    wb_read(4'd12, rd); check("post_rst_ctl0", rd, 16'h000F);
    wb_read(4'd5, rd);  check("post_rst_prm", rd, 16'h0007);
    wb_read(4'd4, rd);  check("post_rst_mask", rd, 16'h000F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
